// File: rtl/dbg_stream_bridge_pkg.sv
// dbg_stream_bridge_pkg: FSM states and frame constants shared by the debug stream bridge.
package dbg_bridge_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, RELEASE, RESP} state_t;
  localparam logic [7:0] DBG_CMD_NOP = 8'h00;
  localparam logic [31:0] DBG_TIMEOUT_RESP = 32'hDEADBEEF;
  localparam int FRAME_FIELD_BYTES = 4;
endpackage

// File: rtl/dbg_stream_bridge_if.sv
// dbg_stream_bridge_if: host byte streams plus core debug port; master = bridge side.
interface dbg_stream_bridge_if;
  logic [7:0] rx_data_i;
  logic rx_valid_i;
  logic rx_ready_o;
  logic [7:0] tx_data_o;
  logic tx_valid_o;
  logic tx_ready_i;
  logic [7:0] dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i;
  logic dbg_ready_i;
  logic busy_o;
  modport master (
    input rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o, dbg_data_o, busy_o
  );
  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
    input rx_ready_o, tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o, dbg_data_o, busy_o
  );
endinterface

// File: rtl/dbg_stream_bridge.sv
// dbg_stream_bridge: assembles 9-byte host frames into debug commands and streams back 4 read bytes.
// Optional ISSUE timeout enabled by defining DBG_BRIDGE_TIMEOUT_EN.
module dbg_stream_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic sys_clk_i,
  input logic rstn_i,
  dbg_stream_bridge_if.master bus
);
  state_t state;
  logic [1:0] cnt;
  logic [7:0] cmd;
  logic [31:0] addr, wdata, resp;
  logic rx_fire, last;
  assign rx_fire = bus.rx_valid_i && bus.rx_ready_o;
  assign last = cnt == 2'(FRAME_FIELD_BYTES - 1);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
`ifdef DBG_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic tmo;
  assign tmo = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt <= '0;
      cmd <= '0;
      addr <= '0;
      wdata <= '0;
      resp <= '0;
      bus.rx_ready_o <= 1'b0;
      bus.tx_data_o <= '0;
      bus.tx_valid_o <= 1'b0;
      bus.dbg_cmd_o <= DBG_CMD_NOP;
      bus.dbg_addr_o <= '0;
      bus.dbg_data_o <= '0;
      bus.busy_o <= 1'b0;
`ifdef DBG_BRIDGE_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.rx_ready_o <= 1'b1;
          if (rx_fire && bus.rx_data_i != DBG_CMD_NOP) begin
            cmd <= bus.rx_data_i;
            cnt <= '0;
            state <= ADDR;
            bus.busy_o <= 1'b1;
          end
        end
        ADDR: if (rx_fire) begin
          addr[{cnt, 3'b000} +: 8] <= bus.rx_data_i;
          cnt <= cnt + 2'd1;
          if (last) state <= DATA;
        end
        DATA: if (rx_fire) begin
          wdata[{cnt, 3'b000} +: 8] <= bus.rx_data_i;
          cnt <= cnt + 2'd1;
          if (last) begin
            state <= ISSUE;
            bus.rx_ready_o <= 1'b0;
            bus.dbg_cmd_o <= cmd;
            bus.dbg_addr_o <= addr;
            bus.dbg_data_o <= {bus.rx_data_i, wdata[23:0]};
`ifdef DBG_BRIDGE_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        ISSUE: begin
          if (bus.dbg_ready_i) begin
            resp <= bus.dbg_data_i;
            state <= RELEASE;
            bus.dbg_cmd_o <= DBG_CMD_NOP;
          end
`ifdef DBG_BRIDGE_TIMEOUT_EN
          else if (tmo) begin
            resp <= DBG_TIMEOUT_RESP;
            state <= RELEASE;
            bus.dbg_cmd_o <= DBG_CMD_NOP;
          end else tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        // cnt has wrapped back to 0 here, so the response starts at its LSB
        RELEASE: if (!bus.dbg_ready_i) begin
          state <= RESP;
          bus.tx_valid_o <= 1'b1;
          bus.tx_data_o <= resp[7:0];
        end
        RESP: if (bus.tx_ready_i) begin
          cnt <= cnt + 2'd1;
          bus.tx_data_o <= resp[{cnt + 2'd1, 3'b000} +: 8];
          if (last) begin
            state <= IDLE;
            bus.tx_valid_o <= 1'b0;
            bus.rx_ready_o <= 1'b1;
            bus.busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_stream_bridge.sv
// tb_dbg_stream_bridge: directed frames against dbg_stream_bridge with hand-computed expectations.
module tb_dbg_stream_bridge;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  dbg_stream_bridge_if bus();
  dbg_stream_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .sys_clk_i(clk),
    .rstn_i(rstn),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data_i = b;
    bus.rx_valid_i = 1'b1;
    while (!bus.rx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("rx_ready_wait", 32'(n), 32'd0);
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    send_byte(c);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask
  task automatic check_issue(input string tag, input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_cmd"}, 32'(bus.dbg_cmd_o), 32'(c));
    check({tag, "_addr"}, bus.dbg_addr_o, a);
    check({tag, "_data"}, bus.dbg_data_o, d);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready_o), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
  endtask
  task automatic reply(input string tag, input logic [31:0] r, input int hold);
    bus.dbg_data_i = r;
    bus.dbg_ready_i = 1'b1;
    @(negedge clk);
    check({tag, "_release_cmd"}, 32'(bus.dbg_cmd_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {bus.dbg_cmd_o, 7'd0, bus.tx_valid_o, 7'd0, bus.busy_o, 8'd0}, 32'h0000_0100);
    end
    bus.dbg_ready_i = 1'b0;
    bus.dbg_data_i = 32'h0;
  endtask
  task automatic recv_word(input string tag, input logic [31:0] exp, input int stall_at);
    logic [31:0] w = '0;
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!bus.tx_valid_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n == 50) check({tag, "_tx_valid_wait"}, 32'(n), 32'd0);
      if (i == stall_at) begin
        bus.tx_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check({tag, "_stall"}, {23'd0, bus.tx_valid_o, bus.tx_data_o}, {23'd0, 1'b1, exp[8*i +: 8]});
        end
        bus.tx_ready_i = 1'b1;
      end
      w[8*i +: 8] = bus.tx_data_o;
      @(negedge clk);
    end
    bus.tx_ready_i = 1'b0;
    check({tag, "_word"}, w, exp);
    check({tag, "_tx_done"}, 32'(bus.tx_valid_o), 32'd0);
    check({tag, "_idle"}, {bus.busy_o, bus.rx_ready_o}, 32'd1);
  endtask
  initial begin
    bus.rx_data_i = '0;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b0;
    bus.dbg_data_i = '0;
    bus.dbg_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(bus.rx_ready_o), 32'd0);
    check("rst_outputs", {bus.dbg_cmd_o, 6'd0, bus.busy_o, bus.tx_valid_o, bus.tx_data_o, 8'd0}, 32'd0);
    check("rst_addr", bus.dbg_addr_o, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_rx_ready", 32'(bus.rx_ready_o), 32'd1);
    send_frame(8'h01, 32'h1234_5678, 32'hDEAD_BEEF);
    check_issue("f1", 8'h01, 32'h1234_5678, 32'hDEAD_BEEF);
    @(negedge clk);
    check("f1_cmd_stable", 32'(bus.dbg_cmd_o), 32'h01);
    reply("f1", 32'hCAFE_F00D, 0);
    recv_word("f1", 32'hCAFE_F00D, -1);
    check("f1_addr_kept", bus.dbg_addr_o, 32'h1234_5678);
    send_byte(8'h00);
    check("sync0_busy", 32'(bus.busy_o), 32'd0);
    send_byte(8'h00);
    check("sync1_busy", 32'(bus.busy_o), 32'd0);
    send_frame(8'h01, 32'h1234_5678, 32'hDEAD_BEEF);
    check_issue("f2", 8'h01, 32'h1234_5678, 32'hDEAD_BEEF);
    reply("f2", 32'h0BAD_F00D, 3);
    recv_word("f2", 32'h0BAD_F00D, 1);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'hA5);
    rstn = 1'b0;
    #1;
    check("mid_rst_flags", {bus.busy_o, bus.rx_ready_o, bus.tx_valid_o}, 32'd0);
    check("mid_rst_cmd", 32'(bus.dbg_cmd_o), 32'd0);
    check("mid_rst_addr", bus.dbg_addr_o, 32'd0);
    check("mid_rst_data", bus.dbg_data_o, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_frame(8'h02, 32'hA5A5_0001, 32'h0000_0000);
    check_issue("f3", 8'h02, 32'hA5A5_0001, 32'h0000_0000);
    reply("f3", 32'h1122_3344, 0);
    recv_word("f3", 32'h1122_3344, -1);
    send_frame(8'h03, 32'h0000_0010, 32'h0000_0001);
    check_issue("f4", 8'h03, 32'h0000_0010, 32'h0000_0001);
`ifdef DBG_BRIDGE_TIMEOUT_EN
    begin
      int n = 0;
      while (bus.dbg_cmd_o != 8'h00 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("tmo_cycles", 32'(n), 32'd16);
    end
    recv_word("tmo", 32'hDEAD_BEEF, -1);
`else
    repeat (1000) @(negedge clk);
    check("no_tmo_cmd", 32'(bus.dbg_cmd_o), 32'h03);
    check("no_tmo_flags", {bus.busy_o, bus.rx_ready_o, bus.tx_valid_o}, 32'b100);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dbg_stream_bridge.md
Name: dbg_stream_bridge

Overview:
- Upstream feeder of the core's debug port.
- Accepts a host byte stream (e.g. from a UART RX/TX pair or a simulation driver) and assembles fixed 9-byte command frames.
- Drives the debug cmd/addr/data lines into core_wrapper, waits for completion, and returns the 32-bit debug read data as 4 bytes on the outgoing stream.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for dbg_ready_i before aborting. Used only with the optional feature.

Ports:
- sys_clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- rx_data_i  in  8  incoming host byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  bridge accepts byte this cycle
- tx_data_o  out  8  outgoing response byte
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  sink accepts byte
- dbg_cmd_o  out  8  debug command to core (0x00 = NOP)
- dbg_addr_o  out  32  debug address
- dbg_data_o  out  32  debug write data
- dbg_data_i  in  32  debug read data from core
- dbg_ready_i  in  1  core: current command complete (level, held until cmd returns to NOP)
- busy_o  out  1  frame in progress (any state other than IDLE)

Behaviour:
- Interface: one clock, sys_clk_i; reset rstn_i is asynchronous, active-low.
- Reset values: all outputs 0. rx_ready_o=0 during reset; state=IDLE; internal address, data and response registers cleared.
- Frame format: byte0 = cmd; bytes1-4 = addr, LSB first; bytes5-8 = wdata, LSB first.
- Byte transfers: a byte moves on any edge where valid&&ready. The same rule applies on the tx side.
- IDLE:
  - rx_ready_o=1.
  - A received 0x00 is discarded; this gives host resync.
  - A non-zero byte is latched as cmd and the FSM goes to ADDR with byte count 0.
- ADDR: rx_ready_o=1. Each accepted byte goes into addr[8*cnt+:8]. After the 4th byte, go to DATA.
- DATA: same shifting into wdata. After the 4th byte, go to ISSUE.
- ISSUE:
  - rx_ready_o=0.
  - dbg_cmd_o=cmd; dbg_addr_o and dbg_data_o are driven from their registers. All are stable for the whole state.
  - On the first edge with dbg_ready_i=1, capture dbg_data_i into resp and go to RELEASE.
- RELEASE: dbg_cmd_o=0. Wait until dbg_ready_i=0, then go to RESP.
  - If ready is already low on entry, leave after 1 cycle.
- RESP:
  - tx_valid_o=1, tx_data_o=resp[8*cnt+:8], starting at the LSB.
  - Hold byte and valid until tx_ready_i.
  - After the 4th accepted byte, go to IDLE.
- Latency:
  - ISSUE is entered on the edge that accepts byte 8.
  - dbg_cmd_o is visible the cycle after that edge.
  - Minimum frame-to-first-tx-byte is 3 cycles when dbg_ready_i is high immediately and tx_ready_i=1.
- dbg_addr_o and dbg_data_o keep their last values outside ISSUE.
- dbg_cmd_o is non-zero only in ISSUE.
- rx_valid_i outside IDLE/ADDR/DATA is ignored (rx_ready_o=0); no bytes are dropped silently.
- Reset mid-frame: everything is cleared immediately; partial frames are lost and the core sees NOP.

Optional Feature:
- Macro: DBG_BRIDGE_TIMEOUT_EN.
- With the macro:
  - A counter runs in ISSUE.
  - If dbg_ready_i is not seen within TIMEOUT_CYCLES cycles, resp=0xDEADBEEF and the FSM goes to RELEASE.
  - The counter clears on ISSUE entry.
- Without the macro: ISSUE waits indefinitely, and no counter logic is synthesized.

Decomposition:
- Package dbg_bridge_pkg:
  - state enum (IDLE, ADDR, DATA, ISSUE, RELEASE, RESP)
  - DBG_CMD_NOP=8'h00
  - DBG_TIMEOUT_RESP=32'hDEADBEEF
  - FRAME_FIELD_BYTES=4
- No sub-module. A single 2-bit byte counter is shared by ADDR, DATA and RESP.

Test Plan:
- Send frame 01 78 56 34 12 EF BE AD DE -> dbg_cmd_o=0x01, dbg_addr_o=0x12345678, dbg_data_o=0xDEADBEEF during ISSUE. Core raises ready with dbg_data_i=0xCAFEF00D -> tx bytes 0D F0 FE CA.
- Leading 00 00 before the frame -> both ignored, busy_o stays 0; the frame then decodes as above.
- tx_ready_i low for 5 cycles mid-response -> tx_data_o/tx_valid_o held constant, no byte lost or duplicated.
- Hold dbg_ready_i=1 for 3 cycles after capture -> bridge stays in RELEASE with dbg_cmd_o=0 and no tx until ready drops.
- Assert rstn_i low after byte 5 of a frame -> outputs 0 immediately. A new full frame afterwards decodes correctly.
- With DBG_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, never assert dbg_ready_i -> after 16 cycles the tx bytes are EF BE AD DE. Without the macro, still in ISSUE after 1000 cycles.
